// File: rtl/cpu_control_fsm_pkg.sv
// Shared codes for the 6502 softcore control path: sequencer states, decoder
// field encodings, instruction classes and the packed strobe bundle.
package cpu_control_fsm_pkg;

  localparam logic [2:0] S_FETCH   = 3'd0;
  localparam logic [2:0] S_DECODE  = 3'd1;
  localparam logic [2:0] S_OPER_LO = 3'd2;
  localparam logic [2:0] S_OPER_HI = 3'd3;
  localparam logic [2:0] S_MEM_RD  = 3'd4;
  localparam logic [2:0] S_EXEC    = 3'd5;
  localparam logic [2:0] S_MEM_WR  = 3'd6;
  localparam logic [2:0] S_HALT    = 3'd7;

  localparam logic [1:0] AM_IMPL = 2'd0;
  localparam logic [1:0] AM_IMM  = 2'd1;
  localparam logic [1:0] AM_ZP   = 2'd2;
  localparam logic [1:0] AM_ABS  = 2'd3;

  localparam logic [2:0] DEST_NONE = 3'd0;
  localparam logic [2:0] DEST_A    = 3'd1;
  localparam logic [2:0] DEST_X    = 3'd2;
  localparam logic [2:0] DEST_Y    = 3'd3;
  localparam logic [2:0] DEST_MEM  = 3'd4;

  localparam logic [7:0] I_NOP = 8'h00;
  localparam logic [7:0] I_LDA = 8'h01;
  localparam logic [7:0] I_LDX = 8'h02;
  localparam logic [7:0] I_LDY = 8'h03;
  localparam logic [7:0] I_STA = 8'h04;
  localparam logic [7:0] I_STX = 8'h05;
  localparam logic [7:0] I_STY = 8'h06;
  localparam logic [7:0] I_ADC = 8'h07;
  localparam logic [7:0] I_INC = 8'h08;
  localparam logic [7:0] I_DEC = 8'h09;
  localparam logic [7:0] I_JMP = 8'h10;
  localparam logic [7:0] I_BEQ = 8'h20;
  localparam logic [7:0] I_BNE = 8'h21;
  localparam logic [7:0] I_BCS = 8'h22;
  localparam logic [7:0] I_BCC = 8'h23;
  localparam logic [7:0] I_BMI = 8'h24;
  localparam logic [7:0] I_BPL = 8'h25;
  localparam logic [7:0] I_BVC = 8'h26;
  localparam logic [7:0] I_BVS = 8'h27;

  typedef struct packed {
    logic mem_req;
    logic mem_we;
    logic addr_sel;
    logic wdata_sel;
    logic ir_load;
    logic op_lo_load;
    logic op_hi_load;
    logic mdr_load;
    logic pc_inc;
    logic pc_jmp;
    logic pc_rel;
    logic alu_en;
    logic reg_we;
    logic flags_we;
    logic halted;
  } ctrl_t;

  function automatic logic is_reg_dest(input logic [2:0] dest);
    return (dest == DEST_A) || (dest == DEST_X) || (dest == DEST_Y);
  endfunction

endpackage

// File: rtl/cpu_control_fsm_branch_cond.sv
// Conditional-branch evaluator: decides whether a branch class is taken
// given the current status flags. Non-branch classes never take.
module cpu_control_fsm_branch_cond
  import cpu_control_fsm_pkg::*;
(
  input  logic [7:0] instr_type_i,
  input  logic       flag_z_i,
  input  logic       flag_c_i,
  input  logic       flag_n_i,
  input  logic       flag_v_i,
  output logic       take_o
);

  always_comb begin
    take_o = 1'b0;
    case (instr_type_i)
      I_BEQ:   take_o = flag_z_i;
      I_BNE:   take_o = !flag_z_i;
      I_BCS:   take_o = flag_c_i;
      I_BCC:   take_o = !flag_c_i;
      I_BMI:   take_o = flag_n_i;
      I_BPL:   take_o = !flag_n_i;
      I_BVS:   take_o = flag_v_i;
      I_BVC:   take_o = !flag_v_i;
      default: take_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle instruction sequencer for the 6502 softcore: fetches opcode and
// operands over a req/ready bus and issues one-cycle datapath strobes.
module cpu_control_fsm
  import cpu_control_fsm_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       mem_ready,
  input  logic       use_alu,
  input  logic       mem_read,
  input  logic       mem_write,
  input  logic [1:0] addr_mode,
  input  logic [1:0] instr_size,
  input  logic [7:0] instr_type,
  input  logic [2:0] reg_dest,
  input  logic       flag_z,
  input  logic       flag_c,
  input  logic       flag_n,
  input  logic       flag_v,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic       wdata_sel,
  output logic       ir_load,
  output logic       op_lo_load,
  output logic       op_hi_load,
  output logic       mdr_load,
  output logic       pc_inc,
  output logic       pc_jmp,
  output logic       pc_rel,
  output logic       alu_en,
  output logic       reg_we,
  output logic       flags_we,
  output logic       halted
);

  localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

  logic [2:0] state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       fetch_pend_q, fetch_pend_d;
  logic       br_take;
  ctrl_t      ctrl, ctrl_out;

  cpu_control_fsm_branch_cond u_branch_cond (
    .instr_type_i (instr_type),
    .flag_z_i     (flag_z),
    .flag_c_i     (flag_c),
    .flag_n_i     (flag_n),
    .flag_v_i     (flag_v),
    .take_o       (br_take)
  );

  always_comb begin
    ctrl    = '0;
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        // Once a fetch is on the bus it stays there even if run drops.
        if (run || fetch_pend_q) begin
          ctrl.mem_req = 1'b1;
          if (mem_ready) begin
            ctrl.ir_load = 1'b1;
            ctrl.pc_inc  = 1'b1;
            state_d      = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        state_d = (instr_size <= 2'd1) ? S_EXEC : S_OPER_LO;
      end
      S_OPER_LO: begin
        ctrl.mem_req = 1'b1;
        if (mem_ready) begin
          ctrl.op_lo_load = 1'b1;
          ctrl.pc_inc     = 1'b1;
          if (instr_size == 2'd3)                   state_d = S_OPER_HI;
          else if (mem_read && addr_mode == AM_ZP)  state_d = S_MEM_RD;
          else                                      state_d = S_EXEC;
        end
      end
      S_OPER_HI: begin
        ctrl.mem_req = 1'b1;
        if (mem_ready) begin
          ctrl.op_hi_load = 1'b1;
          ctrl.pc_inc     = 1'b1;
          state_d         = S_EXEC;
        end
      end
      S_MEM_RD: begin
        ctrl.mem_req  = 1'b1;
        ctrl.addr_sel = 1'b1;
        if (mem_ready) begin
          ctrl.mdr_load = 1'b1;
          state_d       = S_EXEC;
        end
      end
      S_EXEC: begin
        ctrl.alu_en = use_alu;
        if (!mem_write && is_reg_dest(reg_dest)) begin
          ctrl.reg_we   = 1'b1;
          ctrl.flags_we = 1'b1;
        end
        ctrl.pc_jmp = (instr_type == I_JMP);
        ctrl.pc_rel = br_take;
        state_d     = mem_write ? S_MEM_WR : S_FETCH;
      end
      S_MEM_WR: begin
        ctrl.mem_req   = 1'b1;
        ctrl.mem_we    = 1'b1;
        ctrl.addr_sel  = 1'b1;
        ctrl.wdata_sel = (reg_dest == DEST_MEM);
        if (mem_ready) begin
          ctrl.flags_we = (reg_dest == DEST_MEM);
          state_d       = S_FETCH;
        end
      end
      S_HALT: begin
        ctrl.halted = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    // Bus watchdog: counts stalled request cycles, cleared whenever no stall.
    wait_d = '0;
    if (ctrl.mem_req && !mem_ready) begin
      wait_d = wait_q + 8'd1;
      if (wait_d >= WAIT_LIM) state_d = S_HALT;
    end
    fetch_pend_d = (state_q == S_FETCH) && ctrl.mem_req && !mem_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_FETCH;
      wait_q       <= '0;
      fetch_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      fetch_pend_q <= fetch_pend_d;
    end
  end

  // Keep every strobe quiet while reset is held, even with run already high.
  assign ctrl_out = rst_n ? ctrl : '0;

  assign mem_req    = ctrl_out.mem_req;
  assign mem_we     = ctrl_out.mem_we;
  assign addr_sel   = ctrl_out.addr_sel;
  assign wdata_sel  = ctrl_out.wdata_sel;
  assign ir_load    = ctrl_out.ir_load;
  assign op_lo_load = ctrl_out.op_lo_load;
  assign op_hi_load = ctrl_out.op_hi_load;
  assign mdr_load   = ctrl_out.mdr_load;
  assign pc_inc     = ctrl_out.pc_inc;
  assign pc_jmp     = ctrl_out.pc_jmp;
  assign pc_rel     = ctrl_out.pc_rel;
  assign alu_en     = ctrl_out.alu_en;
  assign reg_we     = ctrl_out.reg_we;
  assign flags_we   = ctrl_out.flags_we;
  assign halted     = ctrl_out.halted;

endmodule
